freq_meter: RTL and testbench
=============================

FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 100000000, giving the gate window length in i_CLK cycles (1 s at 100 MHz).
REQ-002 SHALL have parameter GB, default 27, giving the gate counter width; GATE_CYCLES-1 SHALL fit in GB bits.
REQ-003 SHALL have parameter W, default 27, giving the result width.
REQ-004 SHALL have port i_CLK, input, 1 bit: the single system clock (100 MHz); all logic is clocked on its rising edge.
REQ-005 SHALL have port i_Reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port i_Enable, input, 1 bit: run continuous measurements while high.
REQ-007 SHALL have port i_Signal, input, 1 bit: measured pulse stream, asynchronous to i_CLK.
REQ-008 SHALL have port o_Count, output, W bits: rising-edge count of the last completed gate window.
REQ-009 SHALL have port o_Overflow, output, 1 bit: the last completed window saturated.
REQ-010 SHALL have port o_Valid, output, 1 bit: one-cycle strobe marking an o_Count/o_Overflow update.
REQ-011 SHALL have port o_Busy, output, 1 bit: high in states ARM and GATE.

Function
REQ-012 SHALL pass i_Signal through a 2-flop synchronizer and then a history flop; edge = sync & ~hist (one-cycle pulse, 3-cycle latency from pin).
REQ-013 SHALL implement FSM states IDLE, ARM and GATE.
REQ-014 IDLE: counters held at 0; i_Enable=1 SHALL cause a transition to ARM.
REQ-015 ARM: SHALL last exactly 2 cycles so the synchronizer/history path settles; no edges counted; then SHALL go to GATE with gate counter=0 and edge counter=0.
REQ-016 GATE: gate counter SHALL increment each cycle; every edge pulse in a GATE cycle SHALL increment the edge counter.
REQ-017 Window end is the GATE cycle with gate counter == GATE_CYCLES-1; an edge in that cycle SHALL be included in the result.
REQ-018 At window end: o_Count <= final edge count and o_Overflow <= saturation flag on the same edge, and o_Valid SHALL be 1 for the following cycle only.
REQ-019 After window end with i_Enable=1, SHALL stay in GATE with both counters restarted at 0 (gapless; the first cycle of the new window counts edges).
REQ-020 After window end with i_Enable=0, SHALL go to IDLE.
REQ-021 Edge counter SHALL saturate at 2^W-1; an edge arriving at saturation SHALL set the window's saturation flag, which is cleared at window start.
REQ-022 i_Enable=0 during ARM or GATE (not at window end) SHALL abort: go to IDLE next cycle, no o_Valid, o_Count/o_Overflow unchanged.
REQ-023 A level held on i_Signal at enable time SHALL NOT produce a count.
REQ-024 o_Busy SHALL be registered: 1 in ARM and GATE, 0 in IDLE.

Reset
REQ-025 i_Reset=1 at a rising edge of i_CLK SHALL force IDLE, all counters 0, synchronizer/history flops 0, o_Count=0, o_Overflow=0, o_Valid=0, o_Busy=0.
REQ-026 Reset SHALL override i_Enable and any pending window end in the same cycle; no o_Valid SHALL follow.

Structure
REQ-027 FSM state encodings and the CLK_HZ=100000000 constant SHALL live in the shared project package.
REQ-028 Synchronizer plus edge detector SHALL be a sub-module named signal_edge_sync (ports i_CLK, i_Reset, i_Signal, o_Edge).
REQ-029 Gate counter and edge counter SHALL be in freq_meter, as a single always block per counter.

Verification (GATE_CYCLES=100, W=8 unless noted)
REQ-030 i_Enable=1 continuously, i_Signal square wave of period 10 cycles -> o_Valid every 100 cycles, o_Count=10 and o_Overflow=0 every window.
REQ-031 W=4, period-4 square wave -> o_Count=15, o_Overflow=1; then period 10 -> o_Count=10, o_Overflow=0 on the next full window.
REQ-032 i_Signal held high before and during enable, no toggles -> o_Count=0 after the first window.
REQ-033 i_Enable dropped at gate cycle 50 -> no o_Valid, o_Count retains the prior value, o_Busy=0 one cycle later.
REQ-034 i_Reset pulsed at gate cycle 99 -> no o_Valid, all outputs 0 the next cycle; re-enable gives the correct count.
REQ-035 Single i_Signal pulse whose edge reaches the counter in the final gate cycle -> counted in that window (o_Count=1), not the next.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared constants and FSM encoding for the gated-window frequency meter.
package freq_meter_pkg;

    localparam int unsigned CLK_HZ     = 32'd100000000;
    localparam int unsigned ARM_CYCLES = 32'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_GATE = 2'd2
    } fm_state_t;

endpackage

// File: rtl/signal_edge_sync.sv
// Two-flop synchronizer for an asynchronous pulse stream plus a history flop
// that turns a synchronized rising transition into a one-cycle pulse.
module signal_edge_sync (
    input  logic i_CLK,
    input  logic i_Reset,
    input  logic i_Signal,
    output logic o_Edge
);

    logic [1:0] sync_r;
    logic       hist_r;

    // Synchronizer chain and history flop
    always_ff @(posedge i_CLK) begin
        if (i_Reset) begin
            sync_r <= 2'b00;
            hist_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[0], i_Signal};
            hist_r <= sync_r[1];
        end
    end

    assign o_Edge = sync_r[1] & ~hist_r;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of i_Signal over back-to-back gate windows of
// GATE_CYCLES clocks and publishes each completed window's count.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 32'd100000000,
    parameter int unsigned GB          = 32'd27,
    parameter int unsigned W           = 32'd27
) (
    input  logic         i_CLK,
    input  logic         i_Reset,
    input  logic         i_Enable,
    input  logic         i_Signal,
    output logic [W-1:0] o_Count,
    output logic         o_Overflow,
    output logic         o_Valid,
    output logic         o_Busy
);

    localparam logic [GB-1:0] GATE_LAST = GB'(GATE_CYCLES - 32'd1);
    localparam logic [W-1:0]  EDGE_MAX  = {W{1'b1}};
    localparam logic [1:0]    ARM_LAST  = 2'(ARM_CYCLES - 32'd1);

    fm_state_t     state_r;
    fm_state_t     state_s;
    logic [1:0]    arm_cnt_r;
    logic [GB-1:0] gate_cnt_r;
    logic [W-1:0]  edge_cnt_r;
    logic          sat_r;
    logic          edge_s;
    logic          window_end_s;
    logic [W-1:0]  final_cnt_s;
    logic          final_sat_s;
    logic          busy_s;
    logic          valid_s;
    logic [W-1:0]  count_r;
    logic          ovf_r;
    logic          valid_r;
    logic          busy_r;

    signal_edge_sync u_edge_sync (
        .i_CLK    (i_CLK),
        .i_Reset  (i_Reset),
        .i_Signal (i_Signal),
        .o_Edge   (edge_s)
    );

    assign window_end_s = (state_r == ST_GATE) && (gate_cnt_r == GATE_LAST);

    // FSM state register
    always_ff @(posedge i_CLK) begin
        if (i_Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; a window end takes priority over an abort
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_Enable) state_s = ST_ARM;
                else          state_s = ST_IDLE;
            end
            ST_ARM: begin
                if (!i_Enable)                 state_s = ST_IDLE;
                else if (arm_cnt_r == ARM_LAST) state_s = ST_GATE;
                else                           state_s = ST_ARM;
            end
            ST_GATE: begin
                if (window_end_s) state_s = i_Enable ? ST_GATE : ST_IDLE;
                else if (!i_Enable) state_s = ST_IDLE;
                else              state_s = ST_GATE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM output decode, registered below
    always_comb begin
        busy_s  = (state_s != ST_IDLE);
        valid_s = window_end_s;
    end

    // Settling delay counter while armed
    always_ff @(posedge i_CLK) begin
        if (i_Reset) begin
            arm_cnt_r <= 2'd0;
        end else if (state_r == ST_ARM) begin
            arm_cnt_r <= arm_cnt_r + 2'd1;
        end else begin
            arm_cnt_r <= 2'd0;
        end
    end

    // Gate counter: restarts at every window end for gapless windows
    always_ff @(posedge i_CLK) begin
        if (i_Reset) begin
            gate_cnt_r <= {GB{1'b0}};
        end else if ((state_r != ST_GATE) || window_end_s) begin
            gate_cnt_r <= {GB{1'b0}};
        end else begin
            gate_cnt_r <= gate_cnt_r + GB'(1'b1);
        end
    end

    // Count including this cycle's edge, saturating at the top value
    always_comb begin
        final_cnt_s = edge_cnt_r;
        final_sat_s = sat_r;
        if (edge_s) begin
            if (edge_cnt_r == EDGE_MAX) final_sat_s = 1'b1;
            else                        final_cnt_s = edge_cnt_r + W'(1'b1);
        end else begin
            final_cnt_s = edge_cnt_r;
            final_sat_s = sat_r;
        end
    end

    // Edge counter
    always_ff @(posedge i_CLK) begin
        if (i_Reset) begin
            edge_cnt_r <= {W{1'b0}};
        end else if ((state_r != ST_GATE) || window_end_s) begin
            edge_cnt_r <= {W{1'b0}};
        end else begin
            edge_cnt_r <= final_cnt_s;
        end
    end

    // Saturation flag for the current window
    always_ff @(posedge i_CLK) begin
        if (i_Reset) begin
            sat_r <= 1'b0;
        end else if ((state_r != ST_GATE) || window_end_s) begin
            sat_r <= 1'b0;
        end else begin
            sat_r <= final_sat_s;
        end
    end

    // Result and status registers
    always_ff @(posedge i_CLK) begin
        if (i_Reset) begin
            count_r <= {W{1'b0}};
            ovf_r   <= 1'b0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            valid_r <= valid_s;
            busy_r  <= busy_s;
            if (window_end_s) begin
                count_r <= final_cnt_s;
                ovf_r   <= final_sat_s;
            end else begin
                count_r <= count_r;
                ovf_r   <= ovf_r;
            end
        end
    end

    assign o_Count    = count_r;
    assign o_Overflow = ovf_r;
    assign o_Valid    = valid_r;
    assign o_Busy     = busy_r;

endmodule

// File: tb/tb_freq_meter.sv
// Randomized bench for freq_meter: two instances (8-bit and 4-bit results)
// share stimulus and are compared every cycle against a window-level model.
module tb_freq_meter;

    localparam int G      = 100;
    localparam int SAMP_N = 20000;

    logic       clk;
    logic       rst;
    logic       en;
    logic       sig;
    logic [7:0] c8;
    logic       ov8, v8, b8;
    logic [3:0] c4;
    logic       ov4, v4, b4;

    freq_meter #(.GATE_CYCLES(G), .GB(7), .W(8)) dut8 (
        .i_CLK(clk), .i_Reset(rst), .i_Enable(en), .i_Signal(sig),
        .o_Count(c8), .o_Overflow(ov8), .o_Valid(v8), .o_Busy(b8)
    );

    freq_meter #(.GATE_CYCLES(G), .GB(7), .W(4)) dut4 (
        .i_CLK(clk), .i_Reset(rst), .i_Enable(en), .i_Signal(sig),
        .o_Count(c4), .o_Overflow(ov4), .o_Valid(v4), .o_Busy(b4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: pin samples per clock edge and the timestamp of the open window
    bit samp [0:SAMP_N-1];
    int cyc     = 0;
    bit active  = 1'b0;
    int start_q = 0;
    bit ev = 1'b0, eb = 1'b0, eo8 = 1'b0, eo4 = 1'b0;
    int ec8 = 0, ec4 = 0;

    int sig_mode = 0;
    bit sig_lvl  = 1'b0;
    int per      = 10;
    int ph       = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    // Rising edges whose pulse reaches the counter at edge q were sampled
    // high at q-2 and low at q-3.
    task automatic model_step();
        int n;
        cyc++;
        if (cyc < SAMP_N) samp[cyc] = sig;
        ev = 1'b0;
        if (rst) begin
            active = 1'b0; eb = 1'b0;
            ec8 = 0; eo8 = 1'b0; ec4 = 0; eo4 = 1'b0;
        end else if (!active) begin
            if (en) begin
                active  = 1'b1;
                start_q = cyc + 3;
            end
            eb = active;
        end else begin
            if (cyc == start_q + G - 1) begin
                n = 0;
                for (int q = start_q; q <= cyc; q++)
                    if (q >= 3 && q < SAMP_N && samp[q-2] && !samp[q-3]) n++;
                ec8 = (n > 255) ? 255 : n;  eo8 = (n > 255);
                ec4 = (n > 15)  ? 15  : n;  eo4 = (n > 15);
                ev  = 1'b1;
                if (en) start_q = cyc + 1;
                else    active  = 1'b0;
            end else if (!en) begin
                active = 1'b0;
            end
            eb = active;
        end
    endtask

    task automatic check_outputs();
        check_val("valid8", {31'd0, v8},  {31'd0, ev});
        check_val("busy8",  {31'd0, b8},  {31'd0, eb});
        check_val("count8", {24'd0, c8},  ec8);
        check_val("ovf8",   {31'd0, ov8}, {31'd0, eo8});
        check_val("valid4", {31'd0, v4},  {31'd0, ev});
        check_val("busy4",  {31'd0, b4},  {31'd0, eb});
        check_val("count4", {28'd0, c4},  ec4);
        check_val("ovf4",   {31'd0, ov4}, {31'd0, eo4});
    endtask

    task automatic drive_sig();
        case (sig_mode)
            0:       sig = sig_lvl;
            1:       sig = (((cyc + ph) % per) < (per / 2));
            default: sig = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            drive_sig();
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_outputs();
        end
    endtask

    task automatic wait_window(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            run(1);
            if (ev) begin
                ok = 1'b1;
                break;
            end
        end
        check_val(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic run_until_rel(input int rel, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (active && (cyc - start_q == rel)) begin
                ok = 1'b1;
                break;
            end
            run(1);
        end
        check_val(tag, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sig = 1'b0;
        run(3);
        check_val("rst_count", {24'd0, c8}, 32'd0);
        check_val("rst_ovf",   {31'd0, ov8}, 32'd0);
        check_val("rst_valid", {31'd0, v8}, 32'd0);
        check_val("rst_busy",  {31'd0, b8}, 32'd0);
        rst = 1'b0;
        run(2);

        // Period-10 square wave, continuous enable
        en = 1'b1; sig_mode = 1; per = 10; ph = int'($urandom_range(0, 9));
        wait_window("win_p10_a");
        for (int k = 0; k < 2; k++) begin
            wait_window("win_p10_b");
            check_val("p10_count8", {24'd0, c8}, 32'd10);
            check_val("p10_ovf8",   {31'd0, ov8}, 32'd0);
            check_val("p10_count4", {28'd0, c4}, 32'd10);
        end

        // Period 4 saturates the 4-bit counter, then recover at period 10
        per = 4; ph = int'($urandom_range(0, 3));
        wait_window("win_p4_a");
        wait_window("win_p4_b");
        check_val("p4_count4", {28'd0, c4}, 32'd15);
        check_val("p4_ovf4",   {31'd0, ov4}, 32'd1);
        check_val("p4_count8", {24'd0, c8}, 32'd25);
        per = 10;
        wait_window("win_rec_a");
        wait_window("win_rec_b");
        check_val("rec_count4", {28'd0, c4}, 32'd10);
        check_val("rec_ovf4",   {31'd0, ov4}, 32'd0);

        // Level held high across enable yields no count
        en = 1'b0; sig_mode = 0; sig_lvl = 1'b1;
        run(6);
        en = 1'b1;
        wait_window("win_level");
        check_val("level_count8", {24'd0, c8}, 32'd0);
        check_val("level_count4", {28'd0, c4}, 32'd0);

        // Abort at gate cycle 50
        en = 1'b0; run(3);
        sig_mode = 2; en = 1'b1;
        run_until_rel(49, "sync_abort");
        en = 1'b0;
        run(1);
        check_val("abort_busy", {31'd0, b8}, 32'd0);
        check_val("abort_keep", {24'd0, c8}, 32'd0);
        run(110);

        // Reset on the final gate cycle suppresses the result
        en = 1'b1;
        run_until_rel(98, "sync_reset");
        rst = 1'b1;
        run(1);
        check_val("rst99_count", {24'd0, c8}, 32'd0);
        check_val("rst99_valid", {31'd0, v8}, 32'd0);
        check_val("rst99_busy",  {31'd0, b8}, 32'd0);
        rst = 1'b0;
        wait_window("win_after_rst_a");
        wait_window("win_after_rst_b");

        // Single pulse landing on the last gate cycle
        sig_mode = 0; sig_lvl = 1'b0;
        wait_window("win_quiet");
        run_until_rel(G - 4, "sync_pulse");
        sig_lvl = 1'b1; run(1);
        sig_lvl = 1'b0; run(2);
        check_val("pulse_valid",  {31'd0, v8}, 32'd1);
        check_val("pulse_count8", {24'd0, c8}, 32'd1);
        check_val("pulse_count4", {28'd0, c4}, 32'd1);
        wait_window("win_after_pulse");
        check_val("pulse_next",   {24'd0, c8}, 32'd0);

        // Random mix of rates, enable drops and resets
        for (int k = 0; k < 20; k++) begin
            en       = ($urandom_range(0, 7) != 0);
            sig_mode = int'($urandom_range(1, 2));
            per      = int'($urandom_range(2, 12));
            ph       = int'($urandom_range(0, 11));
            if ($urandom_range(0, 15) == 0) begin
                rst = 1'b1; run(1); rst = 1'b0;
            end
            run(int'($urandom_range(20, 150)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
